// File: rtl/nibble_packer.sv
// nibble_packer: pops WIDTH-bit words from an upstream FIFO and packs LANES of
// them into one WIDTH*LANES-bit output word, with lane 0 in the least
// significant bits. A flush request emits a partially filled word early.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   fifo_empty upstream FIFO empty flag
//   fifo_read  one-cycle pop request (combinational)
//   fifo_data  FIFO read data, valid the cycle after fifo_read
//   flush      request to emit a partially filled word
//   m_data     packed output word; unfilled lanes read 0
//   m_valid    m_data is valid (registered)
//   m_ready    downstream accept
//   m_lanes    number of filled lanes in m_data
//   m_partial  high when m_lanes < LANES
//   m_parity   XOR of all m_data bits (only with NIBBLE_PACKER_PARITY_EN)
//
// Build option: define NIBBLE_PACKER_PARITY_EN to add the m_parity output.
module nibble_packer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_read,
  input  logic [WIDTH-1:0]       fifo_data,
  input  logic                   flush,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [3:0]             m_lanes,
  output logic                   m_partial
`ifdef NIBBLE_PACKER_PARITY_EN
  ,
  output logic                   m_parity
`endif
);

  typedef enum logic [1:0] {StFetch, StCapture, StSend} state_e;

  state_e state_q, state_d;

  logic [3:0]             cnt_q, cnt_d;
  logic [WIDTH*LANES-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic [3:0]             lanes_q, lanes_d;
  logic                   partial_q, partial_d;

  logic last_lane;
  logic flush_go;
  logic capture;
  logic load_send;
  logic xfer;

  assign last_lane = (cnt_q == 4'(LANES - 1));
  // Flush only wins when the FIFO has nothing to offer and a word is started.
  assign flush_go  = fifo_empty && flush && (cnt_q != 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (!fifo_empty) begin
          state_d = StCapture;
        end else if (flush_go) begin
          state_d = StSend;
        end
      end
      StCapture: state_d = last_lane ? StSend : StFetch;
      StSend: begin
        if (valid_q && m_ready) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // FSM outputs
  always_comb begin
    // Gated by rst so no pop can be lost while the packer is being cleared.
    fifo_read = (state_q == StFetch) && !fifo_empty && !rst;
    capture   = (state_q == StCapture);
    load_send = (capture && last_lane) || ((state_q == StFetch) && flush_go);
    xfer      = (state_q == StSend) && valid_q && m_ready;
  end

  // Datapath next state
  always_comb begin
    data_d    = data_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    lanes_d   = lanes_q;
    partial_d = partial_q;
    if (capture) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (cnt_q == 4'(i)) begin
          data_d[i*WIDTH +: WIDTH] = fifo_data;
        end
      end
      cnt_d = cnt_q + 4'd1;
    end
    if (load_send) begin
      valid_d   = 1'b1;
      lanes_d   = cnt_d;
      partial_d = (cnt_d < 4'(LANES));
    end
    if (xfer) begin
      data_d    = '0;
      cnt_d     = 4'd0;
      valid_d   = 1'b0;
      lanes_d   = 4'd0;
      partial_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      cnt_q     <= 4'd0;
      valid_q   <= 1'b0;
      lanes_q   <= 4'd0;
      partial_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      lanes_q   <= lanes_d;
      partial_q <= partial_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_lanes   = lanes_q;
  assign m_partial = partial_q;

`ifdef NIBBLE_PACKER_PARITY_EN
  logic parity_q, parity_d;

  // Computed from the word being launched so it lines up with m_valid.
  always_comb begin
    parity_d = parity_q;
    if (load_send) begin
      parity_d = ^data_d;
    end
    if (xfer) begin
      parity_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign m_parity = parity_q;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (WIDTH=4, LANES=4).
// A small FIFO model answers fifo_read with data one cycle later.
module tb_nibble_packer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned LANES = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fifo_empty;
  logic                   fifo_read;
  logic [WIDTH-1:0]       fifo_data;
  logic                   flush;
  logic [WIDTH*LANES-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [3:0]             m_lanes;
  logic                   m_partial;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic                   m_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  nibble_packer #(
    .WIDTH(WIDTH),
    .LANES(LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .fifo_data (fifo_data),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_lanes   (m_lanes),
    .m_partial (m_partial)
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    .m_parity  (m_parity)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO model
  logic [WIDTH-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Read-pulse monitor
  int rd_count = 0;
  bit b2b      = 1'b0;
  bit prev_rd  = 1'b0;
  always @(negedge clk) begin
    if (fifo_read) begin
      rd_count++;
      if (prev_rd) b2b = 1'b1;
    end
    prev_rd = fifo_read;
  end

  task automatic push(input logic [WIDTH-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Returns the number of negedges until m_valid, or 0 on timeout.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (m_valid) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(4'h1);  // FIFO non-empty while reset is held
    @(negedge clk);
    n_tests++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", fifo_read); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", m_data); end
    n_tests++; if (m_lanes !== 4'd0) begin n_fail++; $display("FAIL reset_lanes: got %0d want 0", m_lanes); end
    n_tests++; if (m_partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b want 0", m_partial); end
`ifdef NIBBLE_PACKER_PARITY_EN
    n_tests++; if (m_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", m_parity); end
`endif
  endtask

  task automatic test_basic;
    int cyc;
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    push(4'h2); push(4'h3); push(4'h4);
    rd_count = 0; b2b = 1'b0;
    wait_valid(cyc);
    n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", cyc); end
    n_tests++; if (m_data !== 16'h4321) begin n_fail++; $display("FAIL basic_data: got %h want 4321", m_data); end
    n_tests++; if (m_lanes !== 4'd4) begin n_fail++; $display("FAIL basic_lanes: got %0d want 4", m_lanes); end
    n_tests++; if (m_partial !== 1'b0) begin n_fail++; $display("FAIL basic_partial: got %b want 0", m_partial); end
    n_tests++; if (rd_count !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d want 4", rd_count); end
    n_tests++; if (b2b !== 1'b0) begin n_fail++; $display("FAIL basic_b2b: got %b want 0", b2b); end
`ifdef NIBBLE_PACKER_PARITY_EN
    n_tests++; if (m_parity !== 1'b1) begin n_fail++; $display("FAIL basic_parity: got %b want 1", m_parity); end
`endif
    @(negedge clk);  // transfer took place on the edge in between
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_clr_valid: got %b want 0", m_valid); end
    n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL basic_clr_data: got %h want 0000", m_data); end
    n_tests++; if (m_lanes !== 4'd0) begin n_fail++; $display("FAIL basic_clr_lanes: got %0d want 0", m_lanes); end
  endtask

  task automatic test_hold;
    int cyc;
    int base;
    bit stable;
    @(posedge clk); #1;
    m_ready = 1'b0;
    push(4'h5); push(4'h6); push(4'h7); push(4'h8); push(4'h9);
    wait_valid(cyc);
    n_tests++; if (cyc == 0) begin n_fail++; $display("FAIL hold_timeout: got no m_valid want m_valid"); end
    base   = rd_count;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== 16'h8765 || m_lanes !== 4'd4 || m_partial !== 1'b0)
        stable = 1'b0;
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %h/%b want 8765/1", m_data, m_valid); end
    n_tests++; if (rd_count !== base) begin n_fail++; $display("FAIL hold_reads: got %0d want 0", rd_count - base); end
`ifdef NIBBLE_PACKER_PARITY_EN
    n_tests++; if (m_parity !== 1'b0) begin n_fail++; $display("FAIL hold_parity: got %b want 0", m_parity); end
`endif
    // Release, then flush the leftover word 9 as a one-lane partial.
    @(posedge clk); #1;
    m_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    wait_valid(cyc);
    n_tests++; if (m_data !== 16'h0009) begin n_fail++; $display("FAIL hold_tail_data: got %h want 0009", m_data); end
    n_tests++; if (m_lanes !== 4'd1) begin n_fail++; $display("FAIL hold_tail_lanes: got %0d want 1", m_lanes); end
    n_tests++; if (m_partial !== 1'b1) begin n_fail++; $display("FAIL hold_tail_partial: got %b want 1", m_partial); end
  endtask

  task automatic test_flush;
    int cyc;
    int vseen;
    @(posedge clk); #1;
    flush = 1'b0; m_ready = 1'b1;
    push(4'hA); push(4'hB);
    repeat (6) @(posedge clk);
    #1 flush = 1'b1;
    wait_valid(cyc);
    n_tests++; if (m_data !== 16'h00BA) begin n_fail++; $display("FAIL flush_data: got %h want 00ba", m_data); end
    n_tests++; if (m_lanes !== 4'd2) begin n_fail++; $display("FAIL flush_lanes: got %0d want 2", m_lanes); end
    n_tests++; if (m_partial !== 1'b1) begin n_fail++; $display("FAIL flush_partial: got %b want 1", m_partial); end
    @(posedge clk);
    vseen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) vseen++;
    end
    n_tests++; if (vseen !== 0) begin n_fail++; $display("FAIL flush_empty_word: got %0d valid cycles want 0", vseen); end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_idle;
    int rseen;
    int vseen;
    rseen = 0; vseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_read !== 1'b0) rseen++;
      if (m_valid !== 1'b0) vseen++;
    end
    n_tests++; if (rseen !== 0) begin n_fail++; $display("FAIL idle_read: got %0d want 0", rseen); end
    n_tests++; if (vseen !== 0) begin n_fail++; $display("FAIL idle_valid: got %0d want 0", vseen); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(posedge clk); #1;
    push(4'hC); push(4'hD);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0000", m_data); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", m_valid); end
    @(posedge clk); #1;
    push(4'h5); push(4'h6); push(4'h7); push(4'h8);
    wait_valid(cyc);
    n_tests++; if (m_data !== 16'h8765) begin n_fail++; $display("FAIL rmid_word: got %h want 8765", m_data); end
    n_tests++; if (m_lanes !== 4'd4) begin n_fail++; $display("FAIL rmid_lanes: got %0d want 4", m_lanes); end
    @(posedge clk);
  endtask

  task automatic test_reset_send;
    int cyc;
    @(posedge clk); #1;
    m_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    wait_valid(cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rsend_valid: got %b want 0", m_valid); end
    n_tests++; if (m_lanes !== 4'd0) begin n_fail++; $display("FAIL rsend_lanes: got %0d want 0", m_lanes); end
    @(posedge clk); #1;
    m_ready = 1'b1; flush = 1'b1;
    push(4'h1); push(4'h2);
    wait_valid(cyc);
    n_tests++; if (m_data !== 16'h0021) begin n_fail++; $display("FAIL rsend_word: got %h want 0021", m_data); end
    n_tests++; if (m_lanes !== 4'd2) begin n_fail++; $display("FAIL rsend_word_lanes: got %0d want 2", m_lanes); end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_flush();
    test_idle();
    test_reset_mid();
    test_reset_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the FIFO word width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of FIFO words packed per output word, legal range 2..15.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit, the upstream FIFO empty flag.
REQ-006 The block SHALL have port fifo_read, output, 1 bit, a one-cycle pop request to the upstream FIFO.
REQ-007 The block SHALL have port fifo_data, input, WIDTH bits, the FIFO read data, valid the cycle after fifo_read.
REQ-008 The block SHALL have port flush, input, 1 bit, a request to emit a partially filled word.
REQ-009 The block SHALL have port m_data, output, WIDTH*LANES bits, the packed word.
REQ-010 The block SHALL have port m_valid, output, 1 bit, meaning m_data is valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit, the downstream accept signal.
REQ-012 The block SHALL have port m_lanes, output, 4 bits, the number of filled lanes in m_data.
REQ-013 The block SHALL have port m_partial, output, 1 bit, high when m_lanes is less than LANES.

Function
REQ-014 The control logic SHALL be a state machine with states FETCH, CAPTURE and SEND.
REQ-015 In FETCH with fifo_empty=0, fifo_read SHALL be 1 combinationally and the next state SHALL be CAPTURE.
REQ-016 fifo_read SHALL be 0 in every other state, when fifo_empty=1, and while rst=1, so that at most one read is outstanding.
REQ-017 In CAPTURE the block SHALL store fifo_data into lane cnt (lane 0 in bits WIDTH-1:0) and increment cnt.
REQ-018 From CAPTURE the next state SHALL be SEND when cnt was LANES-1, and FETCH otherwise.
REQ-019 In FETCH with fifo_empty=1, flush=1 and cnt!=0, the next state SHALL be SEND with a partial word.
REQ-020 A non-empty FIFO SHALL take priority over flush.
REQ-021 A flush with cnt=0 SHALL be ignored.
REQ-022 In SEND, m_valid SHALL be 1, m_lanes SHALL equal cnt, and unfilled lanes of m_data SHALL read 0.
REQ-023 While m_valid=1 and m_ready=0, m_data, m_lanes and m_partial SHALL be held stable.
REQ-024 While m_valid=1 and m_ready=0, no fifo_read SHALL be issued.
REQ-025 On m_valid and m_ready both 1, the transfer SHALL complete, and on the next edge m_valid=0, cnt=0, the data lanes SHALL clear and the state SHALL be FETCH.
REQ-026 m_valid SHALL be registered; transfer-to-transfer throughput is one input word per 2 cycles plus one SEND cycle per output word.
REQ-027 m_ready asserted while m_valid=0 SHALL have no effect.

Reset
REQ-028 On rst=1 at a clock edge the state SHALL become FETCH and cnt SHALL become 0.
REQ-029 On reset, m_data, m_valid, m_lanes and m_partial SHALL become 0, and rst SHALL take priority over all other inputs.
REQ-030 A reset in any state, including CAPTURE or SEND, SHALL discard any partial word, and the next word SHALL start at lane 0.

Configuration
REQ-031 When NIBBLE_PACKER_PARITY_EN is defined, the block SHALL add output m_parity, 1 bit, registered, equal to the XOR of all bits of m_data, valid with m_valid and 0 on reset.
REQ-032 When NIBBLE_PACKER_PARITY_EN is undefined, port m_parity and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Push FIFO words 1,2,3,4 with m_ready=1 -> m_data=16'h4321, m_lanes=4, m_partial=0; fifo_read is high exactly 4 cycles, never on back-to-back cycles.
REQ-034 Complete word 16'h8765 with m_ready=0 for 10 cycles -> m_valid=1 and m_data=16'h8765 stable for the whole hold, with zero fifo_read pulses.
REQ-035 Push A,B, then fifo_empty=1 and flush=1 -> m_data=16'h00BA, m_lanes=2, m_partial=1; a subsequent flush with cnt=0 produces no m_valid.
REQ-036 rst=1 for one cycle after 2 captures, then push 5,6,7,8 -> outputs are 0 the cycle after reset and the next word is 16'h8765.
REQ-037 fifo_empty=1 for 20 cycles with flush=0 -> fifo_read=0 and m_valid=0 throughout.
REQ-038 With NIBBLE_PACKER_PARITY_EN defined, word 16'h4321 -> m_parity=1; word 16'h8765 -> m_parity=0.
